// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage multiply/divide sequencer owning HI/LO.
// Ports: Clk/Rst (async, active-high); Md_valid/Md_op/Rs_in/Rt_in/Flush carry the EX op;
// Md_stall holds EX; Res_out returns MUL/MFHI/MFLO results; Mul_*/Div_* drive the external units.
module md_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Md_valid,
  input  logic [3:0]  Md_op,
  input  logic [31:0] Rs_in,
  input  logic [31:0] Rt_in,
  input  logic        Flush,
  output logic        Md_stall,
  output logic [31:0] Res_out,
  output logic        Mul_start,
  output logic        Mul_signed,
  output logic [31:0] Mul_a,
  output logic [31:0] Mul_b,
  input  logic        Mul_done,
  input  logic [31:0] Mul_hi,
  input  logic [31:0] Mul_lo,
  output logic        Div_start,
  output logic        Div_signed,
  output logic [31:0] Div_a,
  output logic [31:0] Div_b,
  input  logic        Div_done,
  input  logic [31:0] Div_q,
  input  logic [31:0] Div_r
);
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN_MUL, DRAIN_DIV} state_t;
  state_t state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mul_res_q, mul_res_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, div_a_q, div_a_d, div_b_q, div_b_d;
  logic        res_mul_q, res_mul_d, mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic        mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
  logic        op_ok, is_mul, is_div, is_unit, drain, mf_ok, serve, issue;
  assign op_ok   = Md_valid && Md_op != 4'd0 && Md_op <= 4'd9;
  assign is_mul  = op_ok && Md_op >= 4'd7;
  assign is_div  = op_ok && Md_op <= 4'd2;
  assign is_unit = is_mul || is_div;
  assign drain   = state_q == DRAIN_MUL || state_q == DRAIN_DIV;
  // MT/MF are serviced while an abandoned unit op drains, just as in IDLE
  assign mf_ok   = (state_q == IDLE || drain) && op_ok;
  assign serve   = mf_ok && !Flush;
  assign issue   = state_q == IDLE && !Flush && is_unit;
  assign Md_stall = !Rst && (state_q == MUL_WAIT || state_q == DIV_WAIT || issue || (drain && is_unit));
  assign Res_out = Rst ? 32'd0 :
                   state_q == DONE ? (res_mul_q ? mul_res_q : 32'd0) :
                   (mf_ok && Md_op == 4'd3) ? hi_q :
                   (mf_ok && Md_op == 4'd4) ? lo_q : 32'd0;
  assign Mul_start  = mul_start_q;
  assign Mul_signed = mul_signed_q;
  assign Mul_a      = mul_a_q;
  assign Mul_b      = mul_b_q;
  assign Div_start  = div_start_q;
  assign Div_signed = div_signed_q;
  assign Div_a      = div_a_q;
  assign Div_b      = div_b_q;
  always_comb begin
    state_d      = state_q;
    hi_d         = (serve && Md_op == 4'd5) ? Rs_in : hi_q;
    lo_d         = (serve && Md_op == 4'd6) ? Rs_in : lo_q;
    mul_res_d    = mul_res_q;
    res_mul_d    = res_mul_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    case (state_q)
      IDLE: begin
        if (issue && is_mul) begin
          mul_start_d  = 1'b1;
          mul_signed_d = Md_op != 4'd9;
          mul_a_d      = Rs_in;
          mul_b_d      = Rt_in;
          res_mul_d    = Md_op == 4'd7;
          state_d      = MUL_WAIT;
        end else if (issue) begin
          res_mul_d = 1'b0;
          // a zero divisor skips the unit and just spends one stall cycle
          if (Rt_in != 32'd0) begin
            div_start_d  = 1'b1;
            div_signed_d = Md_op == 4'd1;
            div_a_d      = Rs_in;
            div_b_d      = Rt_in;
            state_d      = DIV_WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      MUL_WAIT: begin
        if (Flush) begin
          state_d = Mul_done ? IDLE : DRAIN_MUL;
        end else if (Mul_done) begin
          mul_res_d = res_mul_q ? Mul_lo : mul_res_q;
          hi_d      = res_mul_q ? hi_q : Mul_hi;
          lo_d      = res_mul_q ? lo_q : Mul_lo;
          state_d   = DONE;
        end
      end
      DIV_WAIT: begin
        if (Flush) begin
          state_d = Div_done ? IDLE : DRAIN_DIV;
        end else if (Div_done) begin
          hi_d    = Div_r;
          lo_d    = Div_q;
          state_d = DONE;
        end
      end
      DONE:      state_d = IDLE;
      DRAIN_MUL: state_d = Mul_done ? IDLE : DRAIN_MUL;
      DRAIN_DIV: state_d = Div_done ? IDLE : DRAIN_DIV;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_res_q    <= 32'd0;
      res_mul_q    <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      div_a_q      <= 32'd0;
      div_b_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_res_q    <= mul_res_d;
      res_mul_q    <= res_mul_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
    end
  end
endmodule
